// File: rtl/onchip_mem_pipelined_if.sv
// onchip_mem_pipelined_if
//   Bus bundle between an interconnect master and the pipelined on-chip
//   memory slave.
//   master drives: chipselect, address, byteenable, read, write, writedata,
//                  debugaccess
//   slave drives:  readdata, readdatavalid
interface onchip_mem_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic                  chipselect;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_W-1:0]     writedata;
  logic                  debugaccess;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output chipselect, address, byteenable, read, write, writedata, debugaccess,
    input  readdata, readdatavalid
  );

  modport slave (
    input  chipselect, address, byteenable, read, write, writedata, debugaccess,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_pipelined.sv
// onchip_mem_pipelined
//   Single-port on-chip memory slave with explicit read pipelining.
//   Reads are accepted every enabled cycle and answered with readdatavalid
//   after 1 (OUT_REG=0) or 2 (OUT_REG=1) enabled cycles. Reads are
//   read-first against a same-cycle write. Out-of-range reads return zero.
//   Writes are byte-lane masked; in ROM mode only debug-master writes are
//   allowed. Disallowed writes set a sticky flag and bump a saturating count.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears pipeline and flags only
//   clken        clock enable; low freezes every register and the memory
//   bus          slave side of onchip_mem_pipelined_if
//   wr_rejected  sticky: at least one write was rejected since reset
//   reject_cnt   saturating count of rejected writes
module onchip_mem_pipelined #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 9,
  parameter int    DEPTH     = 512,
  parameter int    OUT_REG   = 0,
  parameter int    ROM_MODE  = 1,
  parameter string INIT_FILE = "onchip_mem.hex"
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clken,
  onchip_mem_pipelined_if.slave    bus,
  output logic                     wr_rejected,
  output logic [15:0]              reject_cnt
);

  localparam int BE_W = DATA_W / 8;

  // NOTE: the storage array has no reset branch. Clearing it would turn a
  // block RAM into thousands of flops and would wipe the boot image, which
  // must survive reset. Power-up contents come from INIT_FILE through the
  // FPGA memory-initialisation flow.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Request decode
  logic              in_range;
  logic              rd_acc;
  logic              wr_elig;
  logic              wr_allowed;
  logic              wr_ok;
  logic              wr_rej;
  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    in_range   = ({1'b0, bus.address} < (ADDR_W + 1)'(DEPTH));
    rd_acc     = clken & bus.chipselect & bus.read;
    wr_elig    = clken & bus.chipselect & bus.write;
    wr_allowed = ((ROM_MODE == 0) | bus.debugaccess) & in_range;
    wr_ok      = wr_elig & wr_allowed & ~reset;
    wr_rej     = wr_elig & ~wr_allowed;
    // Out-of-range reads look at word 0; the result is zeroed downstream.
    rd_idx     = in_range ? bus.address : '0;
  end

  // Memory write port: byte-lane masked, committed at the accepting edge.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.byteenable[i]) begin
          mem_q[bus.address][8*i +: 8] <= bus.writedata[8*i +: 8];
        end
      end
    end
  end

  // Stage 1: synchronous read register plus per-stage valid and out-of-range
  // bits. Reject tracking shares the same enable.
  logic              vld1_q, vld1_d;
  logic              oor1_q, oor1_d;
  logic [DATA_W-1:0] dat1_q, dat1_d;
  logic              rej_q,  rej_d;
  logic [15:0]       cnt_q,  cnt_d;

  always_comb begin
    // NOTE: every output of this block is given its held value first, so no
    // path leaves a signal unassigned and no latch is inferred.
    vld1_d = vld1_q;
    oor1_d = oor1_q;
    dat1_d = dat1_q;
    rej_d  = rej_q;
    cnt_d  = cnt_q;
    if (clken) begin
      vld1_d = rd_acc;
      if (rd_acc) begin
        oor1_d = ~in_range;
        // Sampled before this edge's write lands: read-first behaviour.
        dat1_d = mem_q[rd_idx];
      end
      if (wr_rej) begin
        rej_d = 1'b1;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    if (reset) begin
      vld1_q <= 1'b0;
      oor1_q <= 1'b0;
      dat1_q <= '0;
      rej_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld1_q <= vld1_d;
      oor1_q <= oor1_d;
      dat1_q <= dat1_d;
      rej_q  <= rej_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wr_rejected = rej_q;
  assign reject_cnt  = cnt_q;

  // Output stage. readdata only changes when a read completes, so it holds
  // its last value while readdatavalid is low.
  if (OUT_REG != 0) begin : g_out_reg
    logic              vld2_q, vld2_d;
    logic [DATA_W-1:0] dat2_q, dat2_d;

    always_comb begin
      vld2_d = vld2_q;
      dat2_d = dat2_q;
      if (clken) begin
        vld2_d = vld1_q;
        if (vld1_q) dat2_d = oor1_q ? '0 : dat1_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld2_q <= 1'b0;
        dat2_q <= '0;
      end else begin
        vld2_q <= vld2_d;
        dat2_q <= dat2_d;
      end
    end

    assign bus.readdata      = dat2_q;
    assign bus.readdatavalid = vld2_q;
  end else begin : g_no_out_reg
    // Stage 1 only loads on an accepted read, so this mux also holds.
    assign bus.readdata      = oor1_q ? '0 : dat1_q;
    assign bus.readdatavalid = vld1_q;
  end

endmodule

// File: doc/onchip_mem_pipelined.md
# onchip_mem_pipelined

Parametrised on-chip memory slave for the Nios system interconnect, the successor to the fixed 512×32 single-port boot ROM. Configurable data width, depth, ROM/RAM mode and optional output register. Adds explicit read pipelining with `readdatavalid`, out-of-range address handling and a saturating count of rejected writes. Sits on the instruction/data master bus as the boot ROM or general scratch RAM, initialised from a hex file.

## Interface

Parameters:
- `DATA_W`, 32: data width in bits; must be a multiple of 8.
- `ADDR_W`, 9: word address width.
- `DEPTH`, 512: number of words; 1 ≤ DEPTH ≤ 2^ADDR_W.
- `OUT_REG`, 0: 0 gives read latency 1; 1 adds an output register for latency 2.
- `ROM_MODE`, 1: 1 accepts writes only with `debugaccess`; 0 accepts all writes.
- `INIT_FILE`, "onchip_mem.hex": memory initialisation file.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `chipselect`, in, 1: slave select.
- `address`, in, ADDR_W: word address.
- `byteenable`, in, DATA_W/8: write byte lanes.
- `read`, in, 1: read request.
- `write`, in, 1: write request.
- `writedata`, in, DATA_W: write data.
- `debugaccess`, in, 1: JTAG debug-master access qualifier.
- `clken`, in, 1: clock enable; low freezes the whole block.
- `readdata`, out, DATA_W: read data.
- `readdatavalid`, out, 1: `readdata` is valid this cycle.
- `wr_rejected`, out, 1: sticky flag, set on any rejected write.
- `reject_cnt`, out, 16: saturating count of rejected writes.

## Operation

- **Accepted read**: `clken & chipselect & read`. There is no `waitrequest`, so every request is accepted in the cycle it is presented.
- **Write eligibility**: a write is `clken & chipselect & write`. It is *allowed* when `(ROM_MODE==0 | debugaccess)` and `address < DEPTH`.
- **Allowed write**: updates only the lanes where `byteenable[i]=1`. All-zero byteenable is an allowed no-op and is not a rejection.
- **Rejected write**: any write that is not allowed. The memory is unchanged, `wr_rejected` is set to 1, and `reject_cnt` increments, saturating at 0xFFFF.
- **Out-of-range read** (`address >= DEPTH`): returns all zeros with normal latency and normal `readdatavalid`.
- **Read-during-write**: the same address in the same cycle returns the OLD data (read-first).
  - With `read` and `write` both high, both are performed.
  - The read returns pre-write contents.
- **Pipeline**: a valid-shift pipeline of depth L = 1 + OUT_REG carries a valid bit and an out-of-range bit per stage.
- **`clken` low**:
  - Memory is neither read nor written.
  - All pipeline stages, `readdata`, `readdatavalid`, `wr_rejected` and `reject_cnt` hold.
  - Requests are ignored, not queued.
- **Reset**:
  - Clears the pipeline valid bits, `readdata` (to 0), `readdatavalid` (to 0), `wr_rejected` (to 0) and `reject_cnt` (to 0).
  - Memory contents are NOT cleared; they keep `INIT_FILE` contents or later writes.
  - Reset takes effect regardless of `clken`.
- **Reset during an in-flight read**: the read is discarded, and no `readdatavalid` is produced for it after reset.

## Timing

- **Read latency**: a read accepted on enabled edge N gives `readdatavalid=1` and valid `readdata` after exactly L further enabled edges.
  - OUT_REG=0: valid in the cycle after acceptance.
  - OUT_REG=1: valid two cycles after acceptance.
  - Stall cycles (`clken=0`) extend this in wall-clock cycles only.
- **Throughput**: one read per enabled cycle; back-to-back reads give back-to-back `readdatavalid`.
- **`readdatavalid`**: high for exactly one enabled cycle per accepted read. When the stall begins with it high, it stays high across `clken=0` cycles.
- **`readdata` hold**: holds its last value when `readdatavalid=0`. It is not forced to zero.
- **Write timing**: memory updates at the accepting edge, and a read on the next enabled cycle sees the new data.
- **Rejection flags**: `wr_rejected` and `reject_cnt` update on the edge after the rejected write.

## Test plan

1. **Reset state and initial contents**: assert reset 3 cycles, then read address 0 with OUT_REG=0. Required:
   - After reset, `readdata=0`, `readdatavalid=0`, `reject_cnt=0`.
   - The read returns the `INIT_FILE` word one cycle later.
2. **ROM protection** (ROM_MODE=1): write 0xDEADBEEF to address 5 with `debugaccess=0`, then read.
   - Required: the read returns the original word, `wr_rejected=1`, `reject_cnt=1`.
   - Repeat with `debugaccess=1`. Required: the read returns 0xDEADBEEF and `reject_cnt` stays 1.
3. **Byte lanes** (ROM_MODE=0): write 0x11223344 to address 7 with `byteenable=4'b0101` over prior 0xAABBCCDD.
   - Required: the read returns 0xAA22CC44.
4. **Pipelined reads with stall** (OUT_REG=1): read addresses 1, 2, 3 on consecutive cycles, and drop `clken` for 2 cycles after the second read.
   - Required: three `readdatavalid` pulses, data in order, each exactly 2 enabled cycles after its request.
5. **Boundary cases** (DEPTH=500, ADDR_W=9):
   - Read address 499. Required: stored data is returned.
   - Read address 500. Required: 0 is returned with `readdatavalid`.
   - Write to address 511. Required: rejected, `reject_cnt` increments.
   - Drive 70000 rejected writes. Required: `reject_cnt` saturates at 0xFFFF.
6. **Read-during-write and mid-read reset**:
   - Read and write the same address in the same cycle. Required: old data is returned, and the next read returns new data.
   - Assert reset the cycle after a read with OUT_REG=1. Required: no `readdatavalid` follows.
